load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, meaning cycles from the mem_read strobe cycle to mem_data_out being valid (range 1..4).
REQ-002 SHALL have parameter MAX_ADDR, default 8'd254, meaning the highest implemented data-memory location.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a request is presented.
REQ-006 SHALL have port req_ready, output, 1, the unit accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-008 SHALL have port req_addr, input, 8, the ALU-computed address.
REQ-009 SHALL have port req_wdata, input, 8, the store data.
REQ-010 SHALL have port resp_valid, output, 1, a completion is presented.
REQ-011 SHALL have port resp_ready, input, 1, the consumer takes the completion.
REQ-012 SHALL have port resp_rdata, output, 8, the load result (8'h00 for stores and errors).
REQ-013 SHALL have port resp_err, output, 1, the address was rejected (REQ-031).
REQ-014 SHALL have port mem_address, output, 8, to the data-memory address.
REQ-015 SHALL have port mem_write_data, output, 8, to the data-memory write data.
REQ-016 SHALL have port mem_write, output, 1, the store strobe.
REQ-017 SHALL have port mem_read, output, 1, the load strobe.
REQ-018 SHALL have port mem_data_out, input, 8, the registered read data from memory.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&req_ready at a rising edge.
REQ-021 SHALL latch req_write/req_addr/req_wdata on handshake and go IDLE->ISSUE (or IDLE->RESP per REQ-031).
REQ-022 SHALL, in ISSUE, assert exactly one of mem_read/mem_write for exactly one cycle; both SHALL never be 1 together.
REQ-023 SHALL hold mem_address/mem_write_data at the latched values from ISSUE until the next handshake.
REQ-024 SHALL move store ISSUE->RESP after one cycle, with resp_rdata=8'h00.
REQ-025 SHALL move load ISSUE->WAIT, count READ_LAT cycles, capture mem_data_out into resp_rdata on the last WAIT edge, then enter RESP.
REQ-026 SHALL give a load resp_valid 2+READ_LAT-1 cycles after the handshake edge (READ_LAT=1: 2 cycles); a store gets resp_valid 2 cycles after the handshake edge.
REQ-027 SHALL hold resp_valid/resp_rdata/resp_err stable in RESP until resp_ready=1, then go RESP->IDLE.
REQ-028 SHALL NOT accept a request in the same cycle a response retires; the earliest next handshake is the cycle after returning to IDLE.
REQ-029 SHALL drive all outputs from registers (mem_read/mem_write registered, not decoded combinationally).

Reset
REQ-030 SHALL, on rst asserted at any time including mid-transaction, force state=IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=8'h00, resp_err=0, mem_read=0, mem_write=0, mem_address=8'h00, mem_write_data=8'h00, and the latency counter to 0, and abandon the in-flight request with no response.

Configuration
REQ-031 SHALL, with macro LSU_RANGE_CHECK_EN defined, route a request with req_addr>MAX_ADDR IDLE->RESP with resp_err=1, resp_rdata=8'h00, and no memory strobe.
REQ-032 SHALL, without LSU_RANGE_CHECK_EN, forward every address to memory and tie resp_err to 0.

Structure
REQ-033 SHALL put the FSM state enum and the 8-bit data/address width constants in shared package lsu_pkg.
REQ-034 SHALL be a single module; no sub-module is required (the latency counter is inline).

Verification
REQ-035 SHALL check: load at addr 8'h05 with memory preloaded 8'h06 -> mem_read high one cycle, resp_valid 2 cycles after handshake, resp_rdata=8'h06, resp_err=0.
REQ-036 SHALL check: store 8'hAA at 8'h10 then load 8'h10 -> one mem_write pulse with mem_write_data=8'hAA, then resp_rdata=8'hAA.
REQ-037 SHALL check: resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, and a new req_valid is not accepted.
REQ-038 SHALL check: with LSU_RANGE_CHECK_EN, load 8'hFF -> no strobe, resp_err=1, resp_rdata=8'h00; without the macro -> mem_read pulses.
REQ-039 SHALL check: rst asserted during WAIT -> mem_read=0 and resp_valid=0 immediately, no response after release, next load completes normally.
REQ-040 SHALL check: READ_LAT=3 load -> resp_valid 4 cycles after the handshake, with the correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: datapath widths and FSM states.
package lsu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues a single memory strobe,
// waits READ_LAT cycles for load data, then holds the completion until taken.
// Optional address range check enabled by defining LSU_RANGE_CHECK_EN.
// Every output comes straight from a flop.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int                READ_LAT = 1,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 8'd254
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              addr_bad;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LAT - 1);

`ifdef LSU_RANGE_CHECK_EN
  assign addr_bad = (req_addr > MAX_ADDR);
`else
  // Range check disabled: every address goes to memory. The comparison is
  // masked off rather than removed so MAX_ADDR stays referenced in this build.
  assign addr_bad = 1'b0 && (req_addr > MAX_ADDR);
`endif

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (addr_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            // Strobe is registered so it is high for the whole ISSUE cycle.
            state_d     = ISSUE;
            mem_read_d  = !req_write;
            mem_write_d = req_write;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          // Stores linger one extra ISSUE cycle (strobe already dropped) so the
          // completion appears two edges after the handshake.
          if (cnt_q == '0) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d        = '0;
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
          end
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d        = '0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_data_out;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready only while sitting in IDLE, so a retiring response never overlaps a new handshake.
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (READ_LAT=1 and READ_LAT=3),
// each with a small registered-read memory model. Stimulus pushes expected
// completions; per-instance monitors pop and compare on each new resp_valid.
module tb_load_store_unit;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic       a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
  logic [7:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_address, a_mem_write_data, a_mem_data_out;
  logic       a_mem_write, a_mem_read;
  // Instance B signals
  logic       b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [7:0] b_req_addr, b_req_wdata, b_resp_rdata, b_mem_address, b_mem_write_data, b_mem_data_out;
  logic       b_mem_write, b_mem_read;

  load_store_unit #(.READ_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .mem_address(a_mem_address), .mem_write_data(a_mem_write_data),
    .mem_write(a_mem_write), .mem_read(a_mem_read), .mem_data_out(a_mem_data_out)
  );

  load_store_unit #(.READ_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_data_out(b_mem_data_out)
  );

  // Memory models: synchronous write, read data appears LAT cycles after the strobe cycle.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_a [4];
  logic [7:0] pipe_b [4];

  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_address] <= a_mem_write_data;
    if (b_mem_write) mem_b[b_mem_address] <= b_mem_write_data;
    pipe_a[0] <= mem_a[a_mem_address];
    pipe_b[0] <= mem_b[b_mem_address];
    for (int i = 1; i < 4; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign a_mem_data_out = pipe_a[LAT_A-1];
  assign b_mem_data_out = pipe_b[LAT_B-1];

  // Strobe accounting
  int cyc = 0;
  int a_rd_n = 0, a_wr_n = 0, a_both_n = 0, b_rd_n = 0, b_wr_n = 0, b_both_n = 0;
  logic [7:0] a_last_wd = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_mem_read) a_rd_n <= a_rd_n + 1;
    if (a_mem_write) begin
      a_wr_n    <= a_wr_n + 1;
      a_last_wd <= a_mem_write_data;
    end
    if (a_mem_read && a_mem_write) a_both_n <= a_both_n + 1;
    if (b_mem_read) b_rd_n <= b_rd_n + 1;
    if (b_mem_write) b_wr_n <= b_wr_n + 1;
    if (b_mem_read && b_mem_write) b_both_n <= b_both_n + 1;
  end

  // Scoreboard
  typedef struct {
    int rdata;
    int err;
    int lat;
    int hs;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for instance A
  bit a_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (a_resp_valid && !a_prev) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_resp", 1, 0);
        end else begin
          e = qa.pop_front();
          chk("a_rdata", int'(a_resp_rdata), e.rdata);
          chk("a_err", int'(a_resp_err), e.err);
          chk("a_latency", cyc - e.hs, e.lat);
        end
      end
      a_prev = a_resp_valid;
    end
  end

  // Monitor for instance B
  bit b_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (b_resp_valid && !b_prev) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_resp", 1, 0);
        end else begin
          e = qb.pop_front();
          chk("b_rdata", int'(b_resp_rdata), e.rdata);
          chk("b_err", int'(b_resp_err), e.err);
          chk("b_latency", cyc - e.hs, e.lat);
        end
      end
      b_prev = b_resp_valid;
    end
  end

  // Present one request, wait for its handshake and optionally push the expected completion.
  task automatic issue(input bit on_b, input bit wr, input int addr, input int wdata,
                       input int exp_rd, input int exp_err, input int exp_lat, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!(on_b ? b_req_ready : a_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", 0, 1);
    if (on_b) begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = 8'(addr); b_req_wdata = 8'(wdata);
    end else begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = 8'(addr); a_req_wdata = 8'(wdata);
    end
    @(posedge clk);
    #1;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.hs = cyc;
    if (push) begin
      if (on_b) qb.push_back(e);
      else      qa.push_back(e);
    end
    @(negedge clk);
    if (on_b) b_req_valid = 1'b0;
    else      a_req_valid = 1'b0;
  endtask

  // Wait (bounded) until the instance is back in IDLE.
  task automatic wait_idle(input bit on_b);
    int n = 0;
    @(negedge clk);
    while (!(on_b ? b_req_ready : a_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    int r0, w0, n;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[8'h05] = 8'h06;
    mem_a[8'hFF] = 8'h3C;
    mem_b[8'h33] = 8'h7E;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(a_req_ready), 1);
    chk("rst_resp_valid", int'(a_resp_valid), 0);
    chk("rst_resp_rdata", int'(a_resp_rdata), 0);
    chk("rst_resp_err", int'(a_resp_err), 0);
    chk("rst_mem_read", int'(a_mem_read), 0);
    chk("rst_mem_write", int'(a_mem_write), 0);
    chk("rst_mem_address", int'(a_mem_address), 0);
    chk("rst_mem_write_data", int'(a_mem_write_data), 0);

    // Plain load from a preloaded location.
    r0 = a_rd_n;
    issue(0, 0, 'h05, 'h00, 'h06, 0, 2, 1);
    wait_idle(0);
    chk("load_read_pulses", a_rd_n - r0, 1);

    // Store then load back.
    w0 = a_wr_n;
    issue(0, 1, 'h10, 'hAA, 'h00, 0, 2, 1);
    wait_idle(0);
    chk("store_write_pulses", a_wr_n - w0, 1);
    chk("store_write_data", int'(a_last_wd), 'hAA);
    chk("store_addr_held", int'(a_mem_address), 'h10);
    issue(0, 0, 'h10, 'h00, 'hAA, 0, 2, 1);
    wait_idle(0);

    // Back-pressure: completion must hold, no new request accepted.
    a_resp_ready = 1'b0;
    issue(0, 0, 'h05, 'h00, 'h06, 0, 2, 1);
    n = 0;
    while (!a_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("stall_resp_timeout", 0, 1);
    r0 = a_rd_n;
    w0 = a_wr_n;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h20; a_req_wdata = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_resp_valid", int'(a_resp_valid), 1);
      chk("stall_resp_rdata", int'(a_resp_rdata), 'h06);
      chk("stall_req_ready", int'(a_req_ready), 0);
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    wait_idle(0);
    repeat (2) @(negedge clk);
    chk("stall_no_write", a_wr_n - w0, 0);
    chk("stall_no_read", a_rd_n - r0, 0);
    chk("stall_mem_untouched", int'(mem_a[8'h20]), 0);

    // Out-of-range address.
    r0 = a_rd_n;
`ifdef LSU_RANGE_CHECK_EN
    issue(0, 0, 'hFF, 'h00, 'h00, 1, 1, 1);
    wait_idle(0);
    chk("range_read_pulses", a_rd_n - r0, 0);
`else
    issue(0, 0, 'hFF, 'h00, 'h3C, 0, 2, 1);
    wait_idle(0);
    chk("range_read_pulses", a_rd_n - r0, 1);
`endif

    // Reset while the load is in WAIT: abandoned, no response.
    issue(0, 0, 'h05, 'h00, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_mem_read", int'(a_mem_read), 0);
    chk("midrst_resp_valid", int'(a_resp_valid), 0);
    chk("midrst_mem_address", int'(a_mem_address), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_no_resp", int'(a_resp_valid), 0);
    end
    chk("postrst_req_ready", int'(a_req_ready), 1);
    issue(0, 0, 'h10, 'h00, 'hAA, 0, 2, 1);
    wait_idle(0);

    // READ_LAT=3 instance.
    r0 = b_rd_n;
    issue(1, 0, 'h33, 'h00, 'h7E, 0, 4, 1);
    wait_idle(1);
    chk("b_read_pulses", b_rd_n - r0, 1);
    w0 = b_wr_n;
    issue(1, 1, 'h44, 'h99, 'h00, 0, 2, 1);
    wait_idle(1);
    chk("b_write_pulses", b_wr_n - w0, 1);
    issue(1, 0, 'h44, 'h00, 'h99, 0, 4, 1);
    wait_idle(1);

    chk("a_both_strobes", a_both_n, 0);
    chk("b_both_strobes", b_both_n, 0);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
